// File: rtl/sha256_round_core.sv
// SHA-256 compression core: loads H, runs 64 rounds fed by an external W stream, emits 8 digest words.
// Optional `SHA256_CHAIN_EN adds FIRST so later blocks of a message reuse the retained H registers.
module sha256_round_core (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
`ifdef SHA256_CHAIN_EN
  input  logic        FIRST,
`endif
  input  logic        HK_RDY,
  output logic        HK_SELECTOR,
  output logic [2:0]  H_ADDR,
  output logic [5:0]  K_ADDR,
  input  logic [31:0] HK_D,
  input  logic        W_VALID,
  input  logic [31:0] W_DATA,
  output logic        W_READY,
  output logic        BUSY,
  output logic        DIGEST_VALID,
  output logic [2:0]  DIGEST_IDX,
  output logic [31:0] DIGEST
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_FETCH_K, S_EXEC, S_FINAL, S_OUT
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [5:0]  t, t_n;
  logic [31:0] hreg [8];
  logic [31:0] hreg_n [8];
  logic [31:0] v [8];
  logic [31:0] v_n [8];
  logic [31:0] t1, t2;

  logic        sel_n, w_ready_n, busy_n, dv_n;
  logic [2:0]  h_addr_n, idx_n;
  logic [5:0]  k_addr_n;
  logic [31:0] dig_n;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    t_n     = t;
    hreg_n  = hreg;
    v_n     = v;
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + HK_D + W_DATA;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));

    case (state)
      S_IDLE: begin
        if (START && HK_RDY) begin
`ifdef SHA256_CHAIN_EN
          if (FIRST) begin
            state_n = S_LOAD_H;
            cnt_n   = '0;
          end else begin
            v_n     = hreg;
            t_n     = '0;
            state_n = S_FETCH_K;
          end
`else
          state_n = S_LOAD_H;
          cnt_n   = '0;
`endif
        end
      end
      S_LOAD_H: begin
        // Even cycles present H_ADDR, odd cycles capture the word it returned.
        cnt_n = cnt + 4'd1;
        if (cnt[0]) begin
          hreg_n[cnt[3:1]] = HK_D;
          v_n[cnt[3:1]]    = HK_D;
        end
        if (cnt == 4'd15) begin
          t_n     = '0;
          state_n = S_FETCH_K;
        end
      end
      S_FETCH_K: state_n = S_EXEC;
      S_EXEC: begin
        if (W_VALID) begin
          v_n[7] = v[6];
          v_n[6] = v[5];
          v_n[5] = v[4];
          v_n[4] = v[3] + t1;
          v_n[3] = v[2];
          v_n[2] = v[1];
          v_n[1] = v[0];
          v_n[0] = t1 + t2;
          if (t == 6'd63) begin
            t_n     = '0;
            state_n = S_FINAL;
          end else begin
            t_n     = t + 6'd1;
            state_n = S_FETCH_K;
          end
        end
      end
      S_FINAL: begin
        for (int unsigned i = 0; i < 8; i++) hreg_n[i] = hreg[i] + v[i];
        cnt_n   = '0;
        state_n = S_OUT;
      end
      S_OUT: begin
        cnt_n = cnt + 4'd1;
        if (cnt[2:0] == 3'd7) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered ports line up with the state.
    sel_n     = (state_n == S_FETCH_K) || (state_n == S_EXEC);
    h_addr_n  = (state_n == S_LOAD_H) ? cnt_n[3:1] : '0;
    k_addr_n  = sel_n ? t_n : '0;
    w_ready_n = (state_n == S_EXEC);
    busy_n    = (state_n != S_IDLE);
    dv_n      = (state_n == S_OUT);
    idx_n     = dv_n ? cnt_n[2:0] : '0;
    dig_n     = dv_n ? hreg_n[cnt_n[2:0]] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      t            <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        hreg[i] <= '0;
        v[i]    <= '0;
      end
      HK_SELECTOR  <= 1'b0;
      H_ADDR       <= '0;
      K_ADDR       <= '0;
      W_READY      <= 1'b0;
      BUSY         <= 1'b0;
      DIGEST_VALID <= 1'b0;
      DIGEST_IDX   <= '0;
      DIGEST       <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      t            <= t_n;
      for (int unsigned i = 0; i < 8; i++) begin
        hreg[i] <= hreg_n[i];
        v[i]    <= v_n[i];
      end
      HK_SELECTOR  <= sel_n;
      H_ADDR       <= h_addr_n;
      K_ADDR       <= k_addr_n;
      W_READY      <= w_ready_n;
      BUSY         <= busy_n;
      DIGEST_VALID <= dv_n;
      DIGEST_IDX   <= idx_n;
      DIGEST       <= dig_n;
    end
  end

endmodule
